// File: rtl/da_fir_pkg.sv
// da_fir_pkg: shared FSM state type and width helpers for the DA FIR engine
package da_fir_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic int out_width(input int ww, input int cw, input int taps);
    return ww + cw + $clog2(taps);
  endfunction
  function automatic int rom_width(input int cw, input int aw);
    return cw + aw;
  endfunction
endpackage

// File: rtl/da_lut_rom.sv
// da_lut_rom: asynchronous-read DA partition ROM; word a is the sum of the coefficients selected by the set bits of a
module da_lut_rom
  import da_fir_pkg::*;
#(
  parameter int COEF_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter logic [ADDR_WIDTH*COEF_WIDTH-1:0] COEFS = '0,
  localparam int RW = rom_width(COEF_WIDTH, ADDR_WIDTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic signed [RW-1:0]  data_o
);
  typedef logic [(1<<ADDR_WIDTH)-1:0][RW-1:0] table_t;
  function automatic table_t build();
    table_t t;
    logic signed [COEF_WIDTH-1:0] c;
    t = '0;
    for (int a = 0; a < (1 << ADDR_WIDTH); a++)
      for (int i = 0; i < ADDR_WIDTH; i++)
        if (a[i]) begin
          c = COEFS[i*COEF_WIDTH +: COEF_WIDTH];
          t[a] = t[a] + RW'(c);
        end
    return t;
  endfunction
  localparam table_t ROM = build();
  assign data_o = signed'(ROM[addr_i]);
endmodule

// File: rtl/da_fir_engine.sv
// da_fir_engine: bit-serial distributed-arithmetic FIR, one MSB-first pass per sample; tap k coefficient is COEFS[k*COEF_WIDTH +: COEF_WIDTH].
// Define DA_OUT_ROUND_EN for a rounded, saturated WORD_WIDTH result with sat_flag.
module da_fir_engine
  import da_fir_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int PART_ADDR_WIDTH = 3,
  parameter int NUM_PART = 2,
  parameter logic [NUM_PART*PART_ADDR_WIDTH*COEF_WIDTH-1:0] COEFS = '0,
  localparam int TAPS = NUM_PART*PART_ADDR_WIDTH,
  localparam int OUT_WIDTH = out_width(WORD_WIDTH, COEF_WIDTH, TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WORD_WIDTH-1:0] x,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef DA_OUT_ROUND_EN
  output logic signed [WORD_WIDTH-1:0] y,
  output logic                         sat_flag,
`else
  output logic signed [OUT_WIDTH-1:0]  y,
`endif
  output logic                         busy
);
  localparam int CNTW = $clog2(WORD_WIDTH);
  localparam int RW = rom_width(COEF_WIDTH, PART_ADDR_WIDTH);
  localparam logic [CNTW-1:0] CNT_TOP = CNTW'(WORD_WIDTH-1);
  state_e state_q, state_d;
  logic [TAPS-1:0][WORD_WIDTH-1:0] hist_q, hist_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d, p_sum;
  logic signed [RW-1:0] rom_data [NUM_PART];
  logic accept, last;
  // each partition addresses its ROM with bit cnt_q of its own taps
  for (genvar g = 0; g < NUM_PART; g++) begin : g_part
    logic [PART_ADDR_WIDTH-1:0] addr;
    always_comb begin
      addr = '0;
      for (int i = 0; i < PART_ADDR_WIDTH; i++) addr[i] = hist_q[g*PART_ADDR_WIDTH+i][cnt_q];
    end
    da_lut_rom #(
      .COEF_WIDTH(COEF_WIDTH),
      .ADDR_WIDTH(PART_ADDR_WIDTH),
      .COEFS(COEFS[g*PART_ADDR_WIDTH*COEF_WIDTH +: PART_ADDR_WIDTH*COEF_WIDTH])
    ) u_rom (
      .addr_i(addr),
      .data_o(rom_data[g])
    );
  end
  always_comb begin
    p_sum = '0;
    for (int i = 0; i < NUM_PART; i++) p_sum = p_sum + OUT_WIDTH'(rom_data[i]);
  end
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = (state_q == SHIFT) & (cnt_q == '0);
  assign out_valid = state_q == DONE;
  assign busy      = state_q == SHIFT;
  // the sign bit weighs -2^(W-1), so its partial sum is subtracted
  always_comb begin
    state_d = accept ? SHIFT : (state_q == SHIFT) ? (last ? DONE : SHIFT) :
              (state_q == DONE && !out_ready) ? DONE : IDLE;
    hist_d  = accept ? {hist_q[TAPS-2:0], x} : hist_q;
    cnt_d   = accept ? CNT_TOP : (state_q == SHIFT && !last) ? cnt_q - 1'b1 : cnt_q;
    acc_d   = accept ? '0 : (state_q == SHIFT) ?
              (acc_q <<< 1) + ((cnt_q == CNT_TOP) ? -p_sum : p_sum) : acc_q;
  end
`ifdef DA_OUT_ROUND_EN
  localparam logic signed [OUT_WIDTH-1:0] Y_MAX = (OUT_WIDTH'(1) <<< (WORD_WIDTH-1)) - 1;
  localparam logic signed [OUT_WIDTH-1:0] Y_MIN = -Y_MAX - 1;
  logic signed [OUT_WIDTH-1:0] rnd;
  logic signed [WORD_WIDTH-1:0] y_q, y_d;
  logic sat_q, sat_d;
  always_comb begin
    rnd   = (acc_d + (OUT_WIDTH'(1) <<< (COEF_WIDTH-2))) >>> (COEF_WIDTH-1);
    sat_d = (rnd > Y_MAX) | (rnd < Y_MIN);
    y_d   = (rnd > Y_MAX) ? Y_MAX[WORD_WIDTH-1:0] :
            (rnd < Y_MIN) ? Y_MIN[WORD_WIDTH-1:0] : rnd[WORD_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else if (last) sat_q <= sat_d;
  end
  assign sat_flag = sat_q & (state_q == DONE);
`else
  logic signed [OUT_WIDTH-1:0] y_q, y_d;
  assign y_d = acc_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      y_q     <= last ? y_d : y_q;
    end
  end
  assign y = y_q;
endmodule
